// File: rtl/pfx_sum_pipe.sv
// pfx_sum_pipe: consumer end of a parallel-prefix adder. Takes per-bit
// generate/propagate vectors plus carry-in and resolves carries through a
// pipelined Kogge-Stone tree (capture stage R0, then LEVELS prefix stages).
// All stages advance together under a single global enable.
// Optional feature macro: PFX_SUM_OVF_EN adds the two's-complement overflow
// output ovf.
module pfx_sum_pipe #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] g,
  input  logic [DATA_WIDTH-1:0] p,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
`ifdef PFX_SUM_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int unsigned LEVELS = $clog2(DATA_WIDTH);

  // Per-stage registers; index 0 is the capture stage, LEVELS the output stage.
  // Propagate is dead after the last prefix level, so it stops one stage early.
  logic                  vld [0:LEVELS];
  logic                  cr  [0:LEVELS];
  logic [DATA_WIDTH-1:0] gr  [0:LEVELS];
  logic [DATA_WIDTH-1:0] tr  [0:LEVELS];
  logic [DATA_WIDTH-1:0] pr  [0:LEVELS-1];

  logic en;

  assign en       = !vld[LEVELS] || out_ready;
  assign in_ready = en;

  // Capture stage: fold carry-in into bit 0 generate and record half-sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld[0] <= 1'b0;
      cr[0]  <= 1'b0;
      gr[0]  <= '0;
      pr[0]  <= '0;
      tr[0]  <= '0;
    end else if (en) begin
      vld[0] <= in_valid;
      cr[0]  <= cin;
      gr[0]  <= {g[DATA_WIDTH-1:1], g[0] | (p[0] & cin)};
      pr[0]  <= p;
      tr[0]  <= p & ~g;
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    localparam int unsigned D = 1 << (k - 1);

    logic [DATA_WIDTH-1:0] gx;
    logic [DATA_WIDTH-1:0] px;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_comb
        assign gx[i] = gr[k-1][i] | (pr[k-1][i] & gr[k-1][i-D]);
        assign px[i] = pr[k-1][i] & pr[k-1][i-D];
      end else begin : g_pass
        assign gx[i] = gr[k-1][i];
        assign px[i] = pr[k-1][i];
      end
    end

    // Prefix stage k: combine with span D, carry half-sum and cin alongside.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld[k] <= 1'b0;
        cr[k]  <= 1'b0;
        gr[k]  <= '0;
        tr[k]  <= '0;
      end else if (en) begin
        vld[k] <= vld[k-1];
        cr[k]  <= cr[k-1];
        gr[k]  <= gx;
        tr[k]  <= tr[k-1];
      end
    end

    if (k < LEVELS) begin : g_prop
      // Group propagate is only needed by later prefix levels.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pr[k] <= '0;
        end else if (en) begin
          pr[k] <= px;
        end
      end
    end else begin : g_last
      logic unused_px;
      assign unused_px = ^px;
    end
  end

  assign out_valid = vld[LEVELS];
  assign sum       = tr[LEVELS] ^ {gr[LEVELS][DATA_WIDTH-2:0], cr[LEVELS]};
  assign cout      = gr[LEVELS][DATA_WIDTH-1];

`ifdef PFX_SUM_OVF_EN
  assign ovf = gr[LEVELS][DATA_WIDTH-1] ^ gr[LEVELS][DATA_WIDTH-2];
`endif

endmodule
